apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
- APB initiator: converts single-beat commands from an internal requester (sequencer, debug port, or test controller) into APB2/APB3 transfers.
- Drives the APB bus that peripheral slaves (e.g. the level-IRQ controller) sit on.
- Handles wait states (pready), slave errors (pslverr) and a programmable wait-state timeout.
- Returns one response per command.

Parameters:
- ADDR_W, 12, width of cmd_addr/paddr.
- DATA_W, 32, width of write/read data.
- TIMEOUT, 16, maximum ACCESS cycles with pready low before abort; 0 disables the timeout.

Ports:
- pclk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  clock-enable (gating); low freezes all state
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  requester takes the response
- rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
- rsp_err  out  1  pslverr seen, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- paddr  out  ADDR_W  APB address
- pwrite  out  1  APB direction
- psel  out  1  APB select
- penable  out  1  APB enable
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB error

Behaviour:
- Reset (async, reset_n low, any state, including mid-transfer):
  - state = IDLE
  - psel, penable, pwrite, paddr, pwdata = 0
  - rsp_valid, rsp_rdata, rsp_err, rsp_timeout = 0
  - wait counter = 0
  - cmd_ready is combinational from state, so it is 1 while in reset.
- All APB outputs and rsp_* are registered. cmd_ready = (state == IDLE).
- enable low: every register holds its value, including the wait counter; outputs stay stable. Inputs are ignored (no acceptance, no pready sampling).
- FSM states IDLE, SETUP, ACCESS, RESP:
  - IDLE: on cmd_valid & cmd_ready at a clock edge:
    - latch cmd_addr → paddr, cmd_write → pwrite, cmd_wdata → pwdata;
    - psel ← 1, penable ← 0, go to SETUP.
  - SETUP: lasts exactly one cycle; penable ← 1, wait counter ← 0, go to ACCESS.
  - ACCESS: psel = penable = 1; paddr, pwrite, pwdata stable. At each edge:
    - pready = 1: psel ← 0, penable ← 0; rsp_rdata ← (pwrite ? 0 : prdata); rsp_err ← pslverr; rsp_timeout ← 0; rsp_valid ← 1; go to RESP.
    - pready = 0, TIMEOUT ≠ 0 and counter == TIMEOUT−1: abort. psel ← 0, penable ← 0; rsp_rdata ← 0; rsp_err ← 1; rsp_timeout ← 1; rsp_valid ← 1; go to RESP.
    - Otherwise: counter ← counter+1 and stay. The counter saturates and never wraps; width is clog2(TIMEOUT+1), minimum 1.
    - pready high on the same edge the timeout would fire: completion wins, no timeout.
  - RESP: rsp_valid = 1, cmd_ready = 0. On rsp_ready: rsp_valid ← 0, go to IDLE. rsp_rdata, rsp_err and rsp_timeout hold until the next response.
- paddr, pwrite and pwdata keep their last values after a transfer (no forced clear).
- pslverr is sampled only with pready = 1 in ACCESS. prdata is sampled only for reads.
- Throughput: minimum 4 cycles per command (IDLE accept, SETUP, ACCESS, RESP with rsp_ready already high). A new command cannot be accepted in the cycle the response is taken.
- cmd_* signals are don't-care outside IDLE.

Test Plan:
- Reset check: reset_n low → all outputs 0 except cmd_ready = 1. Release reset, write addr 0x000 data 0x0000000A, pready tied 1:
  - psel = 1 for 2 cycles; penable = 1 in the 2nd cycle only; pwdata = 0x0000000A;
  - rsp_valid next cycle with rsp_err = 0, rsp_rdata = 0.
- Read addr 0x004, slave inserts 3 wait states (pready low 3 ACCESS cycles) and returns prdata 0x000000F5:
  - penable high 4 cycles; paddr stable throughout;
  - rsp_rdata = 0x000000F5, rsp_err = 0.
- pready = 1 with pslverr = 1 on a write → rsp_err = 1, rsp_timeout = 0, and the transfer ends normally.
- TIMEOUT = 16, pready held 0 → exactly 16 ACCESS cycles, then psel/penable drop and rsp_err = rsp_timeout = 1, rsp_rdata = 0.
  - Repeat with pready rising in the 16th ACCESS cycle → normal completion, rsp_timeout = 0.
- rsp_ready held 0 for 5 cycles → rsp_valid and data stable, cmd_ready = 0, a pending cmd_valid is not accepted; it is accepted in the cycle after the response is taken.
- Back-to-back commands under enable toggling:
  - enable low mid-ACCESS for 3 cycles → no state change, wait counter frozen.
  - reset_n asserted mid-ACCESS → psel/penable drop immediately (asynchronously) and state returns to IDLE.

Source files
------------

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - single-beat command to APB2/APB3 initiator with wait-state timeout
module apb_cmd_master #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit              TO_EN    = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                pwrite_q, pwrite_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_timeout_q, rsp_timeout_d;

    // enable low freezes every register, including the wait counter
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else if (enable) begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pwrite_q      <= pwrite_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    paddr_d   = cmd_addr;
                    pwrite_d  = cmd_write;
                    pwdata_d  = cmd_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                // completion takes priority over a timeout on the same edge
                if (pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = S_RESP;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = S_RESP;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign paddr       = paddr_q;
    assign pwrite      = pwrite_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwdata      = pwdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - directed self-checking bench for apb_cmd_master
module tb_apb_cmd_master;

    logic        pclk;
    logic        reset_n;
    logic        enable;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [11:0] paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int vec_cnt = 0;
    int err_cnt = 0;

    apb_cmd_master #(
        .ADDR_W (12),
        .DATA_W (32),
        .TIMEOUT(16)
    ) dut (
        .pclk       (pclk),
        .reset_n    (reset_n),
        .enable     (enable),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .paddr      (paddr),
        .pwrite     (pwrite),
        .psel       (psel),
        .penable    (penable),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the SETUP cycle.
    task automatic start_cmd(input logic w, input logic [11:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        @(negedge pclk);
        cmd_valid = 1'b0;
        chk("setup_sel_en", {psel, penable}, 2'b10);
        chk("setup_addr", paddr, a);
        chk("setup_write", pwrite, w);
        chk("setup_wdata", pwdata, d);
        chk("setup_cmd_ready", cmd_ready, 1'b0);
    endtask

    // Called at the SETUP negedge; returns at the negedge of the RESP cycle.
    task automatic run_access(input int waits, input logic [31:0] rd, input logic err,
                              input logic [11:0] a);
        int en_cycles;
        en_cycles = 0;
        pready    = 1'b0;
        for (int i = 0; i < waits; i++) begin
            @(negedge pclk);
            if (psel && penable) en_cycles++;
            chk("acc_addr", paddr, a);
        end
        @(negedge pclk);
        if (psel && penable) en_cycles++;
        chk("acc_addr_last", paddr, a);
        pready  = 1'b1;
        prdata  = rd;
        pslverr = err;
        @(negedge pclk);
        pready  = 1'b0;
        pslverr = 1'b0;
        chk("acc_penable_cycles", en_cycles, waits + 1);
        chk("resp_sel_en", {psel, penable}, 2'b00);
    endtask

    // Called at a negedge in RESP; returns at the following negedge in IDLE.
    task automatic take_rsp(input logic [31:0] exp_rd, input logic exp_err, input logic exp_to);
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_timeout", rsp_timeout, exp_to);
        chk("rsp_cmd_ready", cmd_ready, 1'b0);
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        chk("idle_rsp_valid", rsp_valid, 1'b0);
        chk("idle_cmd_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        int n;
        reset_n   = 1'b1;
        enable    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b1;
        pslverr   = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_apb_ctl", {psel, penable, pwrite}, 3'b000);
        chk("rst_paddr", paddr, 12'h000);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_rsp_flags", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        @(negedge pclk);
        reset_n = 1'b1;
        @(negedge pclk);

        // write, no wait states
        start_cmd(1'b1, 12'h000, 32'h0000_000A);
        run_access(0, 32'hFFFF_FFFF, 1'b0, 12'h000);
        take_rsp(32'h0, 1'b0, 1'b0);

        // read with 3 wait states
        start_cmd(1'b0, 12'h004, 32'h0);
        run_access(3, 32'h0000_00F5, 1'b0, 12'h004);
        take_rsp(32'h0000_00F5, 1'b0, 1'b0);

        // slave error on a write
        start_cmd(1'b1, 12'h008, 32'h0000_0055);
        run_access(0, 32'hDEAD_BEEF, 1'b1, 12'h008);
        take_rsp(32'h0, 1'b1, 1'b0);

        // timeout with pready held low
        prdata = 32'hFFFF_FFFF;
        start_cmd(1'b0, 12'h010, 32'h0);
        pready = 1'b0;
        n = 0;
        @(negedge pclk);
        while (psel && penable && n < 40) begin
            n++;
            @(negedge pclk);
        end
        chk("to_access_cycles", n, 16);
        chk("to_sel_en", {psel, penable}, 2'b00);
        take_rsp(32'h0, 1'b1, 1'b1);

        // pready rises in the 16th ACCESS cycle: completion wins
        start_cmd(1'b0, 12'h014, 32'h0);
        run_access(15, 32'h1234_5678, 1'b0, 12'h014);
        take_rsp(32'h1234_5678, 1'b0, 1'b0);

        // response backpressure with a pending command
        start_cmd(1'b0, 12'h018, 32'h0);
        run_access(0, 32'h0000_0C3C, 1'b0, 12'h018);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 12'h01C;
        cmd_wdata = 32'h0000_0077;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_rsp_rdata", rsp_rdata, 32'h0000_0C3C);
            chk("bp_cmd_ready", cmd_ready, 1'b0);
            chk("bp_psel", psel, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        chk("bp_taken_valid", rsp_valid, 1'b0);
        chk("bp_not_accepted", {cmd_ready, psel}, 2'b10);
        @(negedge pclk);
        cmd_valid = 1'b0;
        chk("bp_accepted", {psel, penable}, 2'b10);
        chk("bp_accept_addr", paddr, 12'h01C);
        run_access(0, 32'h0, 1'b0, 12'h01C);
        take_rsp(32'h0, 1'b0, 1'b0);

        // enable low mid-ACCESS: state and counter frozen, pready ignored
        start_cmd(1'b0, 12'h020, 32'h0);
        pready = 1'b0;
        n = 0;
        @(negedge pclk);
        n++;
        @(negedge pclk);
        n++;
        enable = 1'b0;
        pready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            n++;
            chk("frz_sel_en", {psel, penable}, 2'b11);
        end
        pready = 1'b0;
        enable = 1'b1;
        @(negedge pclk);
        while (psel && penable && n < 60) begin
            n++;
            @(negedge pclk);
        end
        chk("frz_access_cycles", n, 19);
        take_rsp(32'h0, 1'b1, 1'b1);

        // asynchronous reset mid-ACCESS
        start_cmd(1'b1, 12'h024, 32'h0000_0099);
        pready = 1'b0;
        @(negedge pclk);
        chk("ar_pre_sel_en", {psel, penable}, 2'b11);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_sel_en", {psel, penable}, 2'b00);
        chk("ar_cmd_ready", cmd_ready, 1'b1);
        @(negedge pclk);
        reset_n = 1'b1;
        @(negedge pclk);
        start_cmd(1'b0, 12'h028, 32'h0);
        run_access(1, 32'hA5A5_5A5A, 1'b0, 12'h028);
        take_rsp(32'hA5A5_5A5A, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
